// File: rtl/ccip_c1_tx_arbiter.sv
// ccip_c1_tx_arbiter
//   Collects CCI-P c1 write requests from NUM_SRC producers into per-source
//   FIFOs and forwards them to the shell's c1 TX channel. Sources are served
//   round-robin. Multi-line batches (cl_len 2 or 4) are issued atomically.
//   Nothing is issued while the shell reports c1 almost-full.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-low reset
//   src_valid        per-source line valid
//   src_hdr          per-source c1 header, source i at slice i
//   src_data         per-source 512-bit line data, source i at slice i
//   src_almfull      per-source registered backpressure
//   sRx_c1TxAlmFull  shell c1 almost-full
//   sTx_c1           registered c1 request to the shell
//   error            sticky protocol/overflow error
//   drop_cnt         saturating count of lines dropped on a full FIFO

package ccip_if_pkg;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_3 = 2'b10,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]  rsvd73;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd71;
    t_ccip_clLen cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd57;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  localparam int CCIP_C1_HDR_W = $bits(t_ccip_c1_ReqMemHdr);

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

endpackage

module ccip_c1_tx_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int LFIFO_DEPTH   = 4,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_SRC-1:0]                            src_valid,
  input  logic [NUM_SRC*ccip_if_pkg::CCIP_C1_HDR_W-1:0] src_hdr,
  input  logic [NUM_SRC*512-1:0]                        src_data,
  output logic [NUM_SRC-1:0]                            src_almfull,
  input  logic                                          sRx_c1TxAlmFull,
  output ccip_if_pkg::t_if_ccip_c1_Tx                   sTx_c1,
  output logic                                          error,
  output logic [31:0]                                   drop_cnt
);

  import ccip_if_pkg::*;

  localparam int DEPTH = 1 << LFIFO_DEPTH;
  localparam int CNT_W = LFIFO_DEPTH + 1;
  localparam int SRC_W = $clog2(NUM_SRC);

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_entry;

  typedef enum logic {
    ARB,
    BURST
  } t_state;

  // FIFO storage and bookkeeping
  t_entry                 mem       [NUM_SRC][DEPTH];
  logic [LFIFO_DEPTH-1:0] wrPtr_q   [NUM_SRC];
  logic [LFIFO_DEPTH-1:0] rdPtr_q   [NUM_SRC];
  logic [CNT_W-1:0]       count_q   [NUM_SRC];
  logic [CNT_W-1:0]       count_d   [NUM_SRC];
  t_entry                 pushEntry [NUM_SRC];
  logic [NUM_SRC-1:0]     notEmpty;
  logic [NUM_SRC-1:0]     full;
  logic [NUM_SRC-1:0]     push;
  logic [NUM_SRC-1:0]     drop;
  logic [NUM_SRC-1:0]     pop;
  logic [NUM_SRC-1:0]     almfull_q;
  logic [NUM_SRC-1:0]     almfull_d;

  // Arbiter state
  t_state           state_q, state_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [SRC_W-1:0] lock_q, lock_d;
  logic [1:0]       remaining_q, remaining_d;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] cand;
  int               idx;
  logic             found;
  logic             popValid;
  logic             protoErr;
  t_entry           headEntry;

  // Output, error and drop accounting
  t_if_ccip_c1_Tx tx_q, tx_d;
  logic           error_q, error_d;
  logic [31:0]    dropCnt_q, dropCnt_d;
  logic [32:0]    dropSum;

  function automatic logic [SRC_W-1:0] nextSrc(input logic [SRC_W-1:0] s);
    if (int'(s) == NUM_SRC - 1) return '0;
    return s + 1'b1;
  endfunction

  // Per-source status derived only from registered state and inputs.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pushEntry[i].hdr  = t_ccip_c1_ReqMemHdr'(src_hdr[i*CCIP_C1_HDR_W +: CCIP_C1_HDR_W]);
      pushEntry[i].data = src_data[i*512 +: 512];
      notEmpty[i]       = (count_q[i] != '0);
      full[i]           = (count_q[i] == CNT_W'(DEPTH));
    end
  end

  // Arbitration: round-robin search in ARB, locked source in BURST.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_d      = lock_q;
    remaining_d = remaining_q;
    pop         = '0;
    grant       = rr_q;
    cand        = rr_q;
    idx         = 0;
    found       = 1'b0;
    popValid    = 1'b0;
    protoErr    = 1'b0;

    case (state_q)
      ARB: begin
        for (int k = 0; k < NUM_SRC; k++) begin
          idx = int'(rr_q) + k;
          if (idx >= NUM_SRC) idx = idx - NUM_SRC;
          cand = SRC_W'(idx);
          if (!found && notEmpty[cand]) begin
            found = 1'b1;
            grant = cand;
          end
        end
        popValid = found && !sRx_c1TxAlmFull;
      end
      BURST: begin
        grant    = lock_q;
        popValid = notEmpty[lock_q] && !sRx_c1TxAlmFull;
      end
      default: begin
        state_d = ARB;
      end
    endcase

    headEntry = mem[grant][rdPtr_q[grant]];

    if (popValid) begin
      pop[grant] = 1'b1;
      if (state_q == ARB) begin
        if (headEntry.hdr.sop && headEntry.hdr.cl_len == eCL_LEN_2) begin
          state_d     = BURST;
          lock_d      = grant;
          remaining_d = 2'd1;
        end else if (headEntry.hdr.sop && headEntry.hdr.cl_len == eCL_LEN_4) begin
          state_d     = BURST;
          lock_d      = grant;
          remaining_d = 2'd3;
        end else begin
          // A 3-line batch is illegal; it is flagged and sent as one line.
          protoErr = (headEntry.hdr.cl_len == eCL_LEN_3);
          rr_d     = nextSrc(grant);
        end
      end else begin
        // A new start-of-packet inside a batch is flagged but still forwarded.
        protoErr    = headEntry.hdr.sop;
        remaining_d = remaining_q - 2'd1;
        if (remaining_q == 2'd1) begin
          state_d = ARB;
          rr_d    = nextSrc(lock_q);
        end
      end
    end
  end

  // Push side: a full FIFO still accepts a line when its head leaves this cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i]      = src_valid[i] && (!full[i] || pop[i]);
      drop[i]      = src_valid[i] && full[i] && !pop[i];
      count_d[i]   = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      almfull_d[i] = (DEPTH - int'(count_d[i])) <= ALMFULL_SLACK;
    end
  end

  always_comb begin
    tx_d.valid = popValid;
    tx_d.hdr   = popValid ? headEntry.hdr  : tx_q.hdr;
    tx_d.data  = popValid ? headEntry.data : tx_q.data;

    dropSum = {1'b0, dropCnt_q};
    for (int i = 0; i < NUM_SRC; i++) begin
      dropSum = dropSum + 33'(drop[i]);
    end
    dropCnt_d = dropSum[32] ? 32'hFFFF_FFFF : dropSum[31:0];

    error_d = error_q | protoErr | (|drop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB;
      rr_q        <= '0;
      lock_q      <= '0;
      remaining_q <= '0;
      tx_q        <= '0;
      error_q     <= 1'b0;
      dropCnt_q   <= '0;
      almfull_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      remaining_q <= remaining_d;
      tx_q        <= tx_d;
      error_q     <= error_d;
      dropCnt_q   <= dropCnt_d;
      almfull_q   <= almfull_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
        if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
        count_q[i] <= count_d[i];
      end
    end
  end

  // Line storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wrPtr_q[i]] <= pushEntry[i];
    end
  end

  assign sTx_c1      = tx_q;
  assign error       = error_q;
  assign drop_cnt    = dropCnt_q;
  assign src_almfull = almfull_q;

endmodule

// File: tb/tb_ccip_c1_tx_arbiter.sv
// tb_ccip_c1_tx_arbiter
//   Scoreboard bench for ccip_c1_tx_arbiter with NUM_SRC=2, LFIFO_DEPTH=4,
//   ALMFULL_SLACK=4. A queue-based reference model predicts every emitted
//   line and the cycle it appears; a monitor compares on the falling edge.

module tb_ccip_c1_tx_arbiter;

  import ccip_if_pkg::*;

  localparam int NSRC  = 2;
  localparam int DEPTH = 16;
  localparam int SLACK = 4;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic [NSRC-1:0]               srcValid = '0;
  logic [NSRC*CCIP_C1_HDR_W-1:0] srcHdr = '0;
  logic [NSRC*512-1:0]           srcData = '0;
  logic [NSRC-1:0]               srcAlmfull;
  logic                          almFullIn = 1'b0;
  t_if_ccip_c1_Tx                sTx;
  logic                          errorOut;
  logic [31:0]                   dropCnt;

  always #5 clk = ~clk;

  ccip_c1_tx_arbiter #(
    .NUM_SRC(NSRC),
    .LFIFO_DEPTH(4),
    .ALMFULL_SLACK(SLACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_valid(srcValid),
    .src_hdr(srcHdr),
    .src_data(srcData),
    .src_almfull(srcAlmfull),
    .sRx_c1TxAlmFull(almFullIn),
    .sTx_c1(sTx),
    .error(errorOut),
    .drop_cnt(dropCnt)
  );

  typedef struct {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_line;

  typedef struct {
    int                 due;
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_exp;

  t_line           srcQ [NSRC][$];
  t_exp            expQ [$];
  int              cycleCnt = 0;
  int              lockedSrc = -1;
  int              linesLeft = 0;
  int              rrSrc = 0;
  logic            expErr = 1'b0;
  longint          expDrop = 0;
  logic [NSRC-1:0] expAlm = '0;
  int              mPop;
  t_line           mLine;
  t_exp            mExp;
  t_exp            mOut;
  int              total = 0;
  int              bad = 0;

  task automatic checkOutput(input string name, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-source line queues, whole-packet arbitration.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSRC; s++) srcQ[s].delete();
      expQ.delete();
      lockedSrc = -1;
      linesLeft = 0;
      rrSrc     = 0;
      expErr    = 1'b0;
      expDrop   = 0;
      expAlm    = '0;
    end else begin
      cycleCnt++;
      mPop = -1;
      if (!almFullIn) begin
        if (lockedSrc < 0) begin
          for (int k = 0; k < NSRC; k++) begin
            if (mPop < 0 && srcQ[(rrSrc + k) % NSRC].size() > 0) mPop = (rrSrc + k) % NSRC;
          end
        end else if (srcQ[lockedSrc].size() > 0) begin
          mPop = lockedSrc;
        end
      end
      if (mPop >= 0) begin
        mLine    = srcQ[mPop].pop_front();
        mOut.due  = cycleCnt;
        mOut.hdr  = mLine.hdr;
        mOut.data = mLine.data;
        expQ.push_back(mOut);
        if (lockedSrc < 0) begin
          if (mLine.hdr.sop && mLine.hdr.cl_len == eCL_LEN_2) begin
            lockedSrc = mPop;
            linesLeft = 1;
          end else if (mLine.hdr.sop && mLine.hdr.cl_len == eCL_LEN_4) begin
            lockedSrc = mPop;
            linesLeft = 3;
          end else begin
            if (mLine.hdr.cl_len == eCL_LEN_3) expErr = 1'b1;
            rrSrc = (mPop + 1) % NSRC;
          end
        end else begin
          if (mLine.hdr.sop) expErr = 1'b1;
          linesLeft--;
          if (linesLeft == 0) begin
            rrSrc     = (lockedSrc + 1) % NSRC;
            lockedSrc = -1;
          end
        end
      end
      for (int i = 0; i < NSRC; i++) begin
        if (srcValid[i]) begin
          if (srcQ[i].size() < DEPTH) begin
            mLine.hdr  = t_ccip_c1_ReqMemHdr'(srcHdr[i*CCIP_C1_HDR_W +: CCIP_C1_HDR_W]);
            mLine.data = srcData[i*512 +: 512];
            srcQ[i].push_back(mLine);
          end else begin
            expErr = 1'b1;
            if (expDrop < 64'hFFFF_FFFF) expDrop++;
          end
        end
      end
      for (int i = 0; i < NSRC; i++) expAlm[i] = (DEPTH - srcQ[i].size()) <= SLACK;
    end
  end

  // Monitor: compares the DUT against the model every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (expQ.size() > 0 && expQ[0].due == cycleCnt) begin
        mExp = expQ.pop_front();
        checkOutput("txValid", sTx.valid, 1'b1);
        checkOutput("txHdr", sTx.hdr, mExp.hdr);
        checkOutput("txData", sTx.data, mExp.data);
      end else begin
        checkOutput("txIdle", sTx.valid, 1'b0);
      end
      checkOutput("error", errorOut, expErr);
      checkOutput("dropCnt", dropCnt, expDrop[31:0]);
      checkOutput("srcAlmfull", srcAlmfull, expAlm);
    end
  end

  function automatic t_ccip_c1_ReqMemHdr makeHdr(input int src, input logic sop,
                                                 input t_ccip_clLen len, input logic [41:0] addr);
    t_ccip_c1_ReqMemHdr h;
    h         = '0;
    h.sop     = sop;
    h.cl_len  = len;
    h.address = addr;
    h.mdata   = {8'(src), 8'($urandom)};
    return h;
  endfunction

  function automatic logic [511:0] randData();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Drives one cycle of pushes; called and returns at a falling edge.
  task automatic applyStimulus(input logic [NSRC-1:0] vld, input t_ccip_c1_ReqMemHdr h0,
                               input t_ccip_c1_ReqMemHdr h1);
    srcValid = vld;
    srcHdr   = {h1, h0};
    srcData  = {randData(), randData()};
    @(negedge clk);
    srcValid = '0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Valid"}, sTx.valid, 1'b0);
    checkOutput({tag, "Error"}, errorOut, 1'b0);
    checkOutput({tag, "Drop"}, dropCnt, 32'd0);
    checkOutput({tag, "Almfull"}, srcAlmfull, 2'b00);
  endtask

  task automatic resetDut(input string tag);
    #2 reset = 1'b0;
    #1 checkResetState(tag);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int maxCycles);
    int c;
    c = 0;
    while ((expQ.size() > 0 || srcQ[0].size() > 0 || srcQ[1].size() > 0) && c < maxCycles) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    checkOutput("drainLeft", expQ.size() + srcQ[0].size() + srcQ[1].size(), 0);
  endtask

  // Single line pushed into idle arbiter must appear exactly two cycles later.
  task automatic singleLine(input logic [41:0] addr);
    applyStimulus(2'b01, makeHdr(0, 1'b1, eCL_LEN_1, addr), makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    checkOutput("lat1Idle", sTx.valid, 1'b0);
    @(negedge clk);
    checkOutput("lat2Valid", sTx.valid, 1'b1);
    checkOutput("lat2Addr", sTx.hdr.address, addr);
    checkOutput("lat2Err", errorOut, 1'b0);
    waitDrain(20);
  endtask

  initial begin
    #1000000;
    bad++;
    total++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int nValid;
    int genLeft [NSRC];
    t_ccip_clLen genLen [NSRC];
    logic [NSRC-1:0] vld;
    t_ccip_c1_ReqMemHdr h [NSRC];

    #1 reset = 1'b0;
    #2 checkResetState("rst");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    $display("[TB] single line");
    singleLine(42'h100);

    $display("[TB] round robin");
    resetDut("rr");
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b11, makeHdr(0, 1'b1, eCL_LEN_1, 42'h110 + 42'(k)),
                    makeHdr(1, 1'b1, eCL_LEN_1, 42'h120 + 42'(k)));
    waitDrain(50);

    $display("[TB] atomic batch");
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b11, makeHdr(0, k == 0, eCL_LEN_4, 42'h200 + 42'(k)),
                    makeHdr(1, 1'b1, eCL_LEN_1, 42'h400 + 42'(k)));
    waitDrain(50);

    $display("[TB] almost-full stall");
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b01, makeHdr(0, k == 0, eCL_LEN_4, 42'h500 + 42'(k)),
                    makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    almFullIn = 1'b1;
    nValid = 0;
    applyStimulus(2'b01, makeHdr(0, 1'b0, eCL_LEN_4, 42'h503), makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    nValid += int'(sTx.valid);
    repeat (9) begin
      @(negedge clk);
      nValid += int'(sTx.valid);
    end
    checkOutput("stallValidsLe1", nValid <= 1, 1'b1);
    almFullIn = 1'b0;
    waitDrain(50);

    $display("[TB] overflow");
    checkOutput("preOvfErr", errorOut, 1'b0);
    almFullIn = 1'b1;
    for (int k = 0; k < 18; k++) begin
      applyStimulus(2'b10, makeHdr(0, 1'b1, eCL_LEN_1, 42'h0),
                    makeHdr(1, 1'b1, eCL_LEN_1, 42'h600 + 42'(k)));
      if (k == 10) checkOutput("almfullAt11", srcAlmfull[1], 1'b0);
      if (k == 11) checkOutput("almfullAt12", srcAlmfull[1], 1'b1);
    end
    checkOutput("ovfDrop", dropCnt, 32'd2);
    checkOutput("ovfErr", errorOut, 1'b1);
    checkOutput("ovfAlmfull", srcAlmfull[1], 1'b1);
    almFullIn = 1'b0;
    waitDrain(100);

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 3; k++)
      applyStimulus(2'b01, makeHdr(0, k == 0, eCL_LEN_4, 42'h680 + 42'(k)),
                    makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    resetDut("midBurst");
    singleLine(42'h700);

    $display("[TB] illegal length and sop inside batch");
    resetDut("len3");
    applyStimulus(2'b10, makeHdr(0, 1'b1, eCL_LEN_1, 42'h0), makeHdr(1, 1'b1, eCL_LEN_3, 42'h800));
    repeat (2) @(negedge clk);
    checkOutput("len3Err", errorOut, 1'b1);
    waitDrain(20);
    resetDut("sopErr");
    applyStimulus(2'b01, makeHdr(0, 1'b1, eCL_LEN_2, 42'h900), makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    applyStimulus(2'b01, makeHdr(0, 1'b1, eCL_LEN_2, 42'h901), makeHdr(1, 1'b1, eCL_LEN_1, 42'h0));
    repeat (2) @(negedge clk);
    checkOutput("sopErr", errorOut, 1'b1);
    waitDrain(20);

    $display("[TB] random traffic");
    resetDut("rand");
    for (int i = 0; i < NSRC; i++) begin
      genLeft[i] = 0;
      genLen[i]  = eCL_LEN_1;
    end
    for (int c = 0; c < 400; c++) begin
      almFullIn = ($urandom_range(0, 9) < 2);
      vld = '0;
      for (int i = 0; i < NSRC; i++) begin
        h[i] = makeHdr(i, 1'b1, eCL_LEN_1, 42'h0);
        if (genLeft[i] > 0) begin
          if ($urandom_range(0, 9) < 7) begin
            vld[i] = 1'b1;
            h[i] = makeHdr(i, 1'b0, genLen[i], 42'($urandom));
            genLeft[i]--;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          case ($urandom_range(0, 2))
            0:       begin genLen[i] = eCL_LEN_1; genLeft[i] = 0; end
            1:       begin genLen[i] = eCL_LEN_2; genLeft[i] = 1; end
            default: begin genLen[i] = eCL_LEN_4; genLeft[i] = 3; end
          endcase
          vld[i] = 1'b1;
          h[i] = makeHdr(i, 1'b1, genLen[i], 42'($urandom));
        end
      end
      applyStimulus(vld, h[0], h[1]);
    end
    almFullIn = 1'b0;
    waitDrain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
